// File: rtl/arctan_seq.sv
// arctan_seq -- sequential arctan approximation from a three-term Chebyshev
// series (c1=212, c3=-12, c5=1), evaluated by Clenshaw recurrence over one
// shared 2W-bit signed multiplier. One recurrence step is done per clock.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   start        evaluate x_in; only looked at while idle
//   x_in         signed argument, units of 1/128
//   busy         recurrence in progress (5 cycles per evaluation)
//   done         one-cycle pulse, f_out newly valid
//   f_out        signed result, held until the next done
//   d_o1..d_o4   registered intermediates d[1]..d[4]
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last evaluation
// RUN   | one recurrence step per cycle, k = 4,3,2,1 then final step k = 0
module arctan_seq #(
  parameter int W = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] f_out,
  output logic signed [W-1:0] d_o1,
  output logic signed [W-1:0] d_o2,
  output logic signed [W-1:0] d_o3,
  output logic signed [W-1:0] d_o4
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [2:0]          k_q;
  logic signed [W-1:0] x_q, dk1_q, dk2_q;
  logic                accept, done_d;

  logic signed [2*W-1:0] prod, bias, quot, coef, dk2_ext, sum;
  logic signed [W-1:0]   d_new;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    accept  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (k_q == 3'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Shared multiplier and step arithmetic. The final step (k=0) divides by
  // 256 instead of 128 and has no coefficient. Negative products get a bias
  // of (divisor-1) so the arithmetic shift truncates toward zero.
  always_comb begin
    prod    = $signed({{W{x_q[W-1]}}, x_q}) * $signed({{W{dk1_q[W-1]}}, dk1_q});
    dk2_ext = $signed({{W{dk2_q[W-1]}}, dk2_q});
    bias    = '0;
    if (prod[2*W-1]) bias = (k_q == 3'd0) ? (2*W)'(255) : (2*W)'(127);
    quot    = (k_q == 3'd0) ? ((prod + bias) >>> 8) : ((prod + bias) >>> 7);
    case (k_q)
      3'd3:    coef = (2*W)'(-12);
      3'd1:    coef = (2*W)'(212);
      default: coef = '0;
    endcase
    sum   = quot - dk2_ext + coef;
    d_new = sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done  <= 1'b0;
      k_q   <= 3'd0;
      x_q   <= '0;
      dk1_q <= '0;
      dk2_q <= '0;
      f_out <= '0;
      d_o1  <= '0;
      d_o2  <= '0;
      d_o3  <= '0;
      d_o4  <= '0;
    end else begin
      done <= done_d;
      if (accept) begin
        // seed d[5]=1, d[6]=0
        x_q   <= x_in;
        dk1_q <= {{(W-1){1'b0}}, 1'b1};
        dk2_q <= '0;
        k_q   <= 3'd4;
      end else if (busy) begin
        if (k_q != 3'd0) begin
          dk2_q <= dk1_q;
          dk1_q <= d_new;
          k_q   <= k_q - 3'd1;
          case (k_q)
            3'd4:    d_o4 <= d_new;
            3'd3:    d_o3 <= d_new;
            3'd2:    d_o2 <= d_new;
            default: d_o1 <= d_new;
          endcase
        end else begin
          f_out <= d_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_arctan_seq.sv
module tb_arctan_seq;
  localparam int W = 9;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic signed [W-1:0] x_in;
  logic                busy, done;
  logic signed [W-1:0] f_out, d_o1, d_o2, d_o3, d_o4;

  int checks = 0;
  int errors = 0;

  arctan_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .f_out(f_out),
    .d_o1(d_o1), .d_o2(d_o2), .d_o3(d_o3), .d_o4(d_o4)
  );

  always #5 clk = ~clk;

  // Reference model: Clenshaw recurrence in plain integer arithmetic.
  // SV integer division truncates toward zero; results wrap to W bits.
  function automatic int wrapw(input int v);
    logic signed [W-1:0] b;
    b = v[W-1:0];
    return int'(b);
  endfunction

  function automatic int cheb(input int k);
    if (k == 3) return -12;
    if (k == 1) return 212;
    return 0;
  endfunction

  task automatic model(input int x, output int d1, output int d2,
                       output int d3, output int d4, output int f);
    int d[0:6];
    d[6] = 0;
    d[5] = 1;
    for (int k = 4; k >= 1; k--)
      d[k] = wrapw((x * d[k+1]) / 128 - d[k+2] + cheb(k));
    f  = wrapw((x * d[1]) / 256 - d[2]);
    d1 = d[1]; d2 = d[2]; d3 = d[3]; d4 = d[4];
  endtask

  // Issue one start and follow it to done. lat counts edges from the
  // start edge to the done edge (0 if it never came), bcnt the busy cycles.
  task automatic run_eval(input int x, output int lat, output int bcnt,
                          output int overlap);
    int n;
    @(negedge clk);
    x_in  = W'(x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_in  = W'($urandom);
    n = 0; bcnt = 0; overlap = 0; lat = 0;
    while (!done && n < 20) begin
      if (busy) bcnt++;
      if (busy && done) overlap++;
      @(negedge clk);
      n++;
    end
    if (done) lat = n;
    if (busy && done) overlap++;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; x_in = 9'sd100;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (f_out !== '0 || d_o1 !== '0 || d_o2 !== '0 || d_o3 !== '0 || d_o4 !== '0) begin
      errors++;
      $display("FAIL reset_data f=%0d d1=%0d d2=%0d d3=%0d d4=%0d expected all 0",
               f_out, d_o1, d_o2, d_o3, d_o4);
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_vector(input int x, input int e1, input int e2,
                             input int e3, input int e4, input int ef);
    int lat, bcnt, ov;
    run_eval(x, lat, bcnt, ov);
    checks++;
    if (lat !== 5 || bcnt !== 5 || ov !== 0) begin
      errors++;
      $display("FAIL timing x=%0d latency=%0d busy_cycles=%0d overlap=%0d expected 5 5 0",
               x, lat, bcnt, ov);
    end
    checks++;
    if (int'(f_out) !== ef || int'(d_o1) !== e1 || int'(d_o2) !== e2 ||
        int'(d_o3) !== e3 || int'(d_o4) !== e4) begin
      errors++;
      $display("FAIL values x=%0d got f=%0d d1=%0d d2=%0d d3=%0d d4=%0d expected f=%0d d1=%0d d2=%0d d3=%0d d4=%0d",
               x, f_out, d_o1, d_o2, d_o3, d_o4, ef, e1, e2, e3, e4);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_width x=%0d done=%b expected 0", x, done);
    end
  endtask

  task automatic test_fixed;
    test_vector(0,    225,   0, -13,  0,    0);
    test_vector(127,  214, -12, -13,  0,  118);
    test_vector(-128, 211,  13, -12, -1, -118);
  endtask

  task automatic test_random;
    int e1, e2, e3, e4, ef, x;
    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(511)) - 256;
      model(x, e1, e2, e3, e4, ef);
      test_vector(x, e1, e2, e3, e4, ef);
    end
  endtask

  task automatic test_hold_on_start;
    int lat, bcnt, ov;
    run_eval(127, lat, bcnt, ov);
    @(negedge clk);
    x_in = -9'sd128; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || int'(d_o1) !== 214 || int'(d_o2) !== -12 || int'(d_o3) !== -13) begin
      errors++;
      $display("FAIL hold_on_start busy=%b d1=%0d d2=%0d d3=%0d expected 1 214 -12 -13",
               busy, d_o1, d_o2, d_o3);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int n, bcnt, dcnt;
    @(negedge clk);
    x_in = 9'sd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bcnt = 0; dcnt = 0;
    for (n = 0; n < 15; n++) begin
      if (n >= 1 && n <= 3) begin x_in = -9'sd128; start = 1'b1; end
      else start = 1'b0;
      if (busy) bcnt++;
      if (done) dcnt++;
      if (done) begin
        checks++;
        if (int'(f_out) !== 61) begin
          errors++; $display("FAIL ignore_start f=%0d expected 61", f_out);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bcnt !== 5 || dcnt !== 1) begin
      errors++;
      $display("FAIL ignore_start_count busy_cycles=%0d dones=%0d expected 5 1", bcnt, dcnt);
    end
  endtask

  task automatic test_back_to_back;
    int n, nd, t[2], v[2];
    nd = 0;
    @(negedge clk);
    x_in = 9'sd127; start = 1'b1;
    for (n = 1; n < 30; n++) begin
      @(negedge clk);
      x_in = '0;
      if (nd == 1 && busy) start = 1'b0;
      if (done) begin
        if (nd < 2) begin t[nd] = n; v[nd] = int'(f_out); end
        nd++;
      end
    end
    start = 1'b0;
    checks++;
    if (nd !== 2) begin
      errors++; $display("FAIL b2b_count dones=%0d expected 2", nd);
    end else begin
      checks++;
      if (t[1] - t[0] !== 6 || v[0] !== 118 || v[1] !== 0) begin
        errors++;
        $display("FAIL b2b spacing=%0d f0=%0d f1=%0d expected 6 118 0",
                 t[1] - t[0], v[0], v[1]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int dcnt, lat, bcnt, ov;
    @(negedge clk);
    x_in = 9'sd127; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || f_out !== '0 || d_o1 !== '0 ||
        d_o2 !== '0 || d_o3 !== '0 || d_o4 !== '0) begin
      errors++;
      $display("FAIL abort busy=%b done=%b f=%0d d1=%0d d2=%0d d3=%0d d4=%0d expected all 0",
               busy, done, f_out, d_o1, d_o2, d_o3, d_o4);
    end
    reset = 1'b1; x_in = 9'sd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL first_start_after_reset busy=%b expected 1", busy);
    end
    dcnt = 0;
    repeat (12) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (dcnt !== 1) begin
      errors++; $display("FAIL abort_done_count dones=%0d expected 1", dcnt);
    end
    run_eval(0, lat, bcnt, ov);
    checks++;
    if (lat !== 5 || int'(f_out) !== 0 || int'(d_o1) !== 225) begin
      errors++;
      $display("FAIL after_abort latency=%0d f=%0d d1=%0d expected 5 0 225", lat, f_out, d_o1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; x_in = '0;
    test_reset();
    test_fixed();
    test_hold_on_start();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arctan_seq.md
ARCTAN_SEQ -- requirements
Module: arctan_seq

Interface
REQ-001 The block SHALL have parameter W, default 9, meaning data width of x_in, f_out and all recurrence registers.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, meaning request to evaluate x_in; sampled only in IDLE.
REQ-005 The block SHALL have port x_in, input, W bits signed, meaning the argument in units of 1/128.
REQ-006 The block SHALL have port busy, output, 1 bit, meaning a recurrence is in progress.
REQ-007 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse marking f_out as newly valid.
REQ-008 The block SHALL have port f_out, output, W bits signed, meaning the arctan approximation, held until the next done.
REQ-009 The block SHALL have ports d_o1..d_o4, output, W bits signed each, meaning the registered intermediates d[1]..d[4] of the current or last evaluation.

Function
REQ-010 The block SHALL evaluate the Chebyshev series c1=212, c3=-12, c5=1 by Clenshaw recurrence using ONE shared multiplier.
- d[6]=0 and d[5]=1.
- For k=4..1: d[k] = (x*d[k+1])/128 - d[k+2] + c_k, with c4=0, c3=-12, c2=0, c1=212.
- Final step: f = (x*d[1])/256 - d[2].
REQ-011 Arithmetic SHALL follow these rules:
- The product SHALL be full 2W-bit signed.
- Division by 128 or 256 SHALL truncate toward zero; an arithmetic shift is not acceptable for negative products.
- Each sum SHALL be formed at 2W bits, then wrapped to its low W bits, with no saturation.
REQ-012 The FSM SHALL have states IDLE and RUN, with a 3-bit step counter k.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL perform the following at that edge:
- Latch x_in.
- Load d[k+1]=1 and d[k+2]=0.
- Set k=4 and enter RUN.
REQ-014 In RUN, the block SHALL compute exactly one recurrence step per cycle, in the order k=4,3,2,1,0.
- At each edge it SHALL shift d[k+1] into d[k+2] and load the new d[k] into d[k+1].
- It SHALL update d_o<k> at that same edge for k=4..1.
REQ-015 At the edge completing step k=0, the block SHALL register f into f_out, drive done=1 for the following cycle and return to IDLE.
REQ-016 Latency SHALL be 5 cycles from the start-accepting edge to the edge that asserts done. busy SHALL be 1 for exactly those 5 cycles, and busy and done SHALL never both be 1.
REQ-017 start SHALL be ignored while busy=1, and x_in changes during RUN SHALL NOT affect the result.
REQ-018 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back throughput of one result per 6 cycles.
REQ-019 f_out and d_o1..d_o4 SHALL hold their values between evaluations. d_o1..d_o4 SHALL NOT be cleared by a new start.

Reset
REQ-020 When reset=0 at a rising edge, the block SHALL enter IDLE and clear the following to 0: busy, done, f_out, d_o1..d_o4, k and all internal registers.
REQ-021 Reset SHALL take priority over start and over an in-progress RUN. An aborted evaluation SHALL produce no done pulse.
REQ-022 After reset is released, the first start SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-023 The bench SHALL cover x_in=0 with a start pulse. Required response: d_o4=0, d_o3=-13, d_o2=0, d_o1=225, f_out=0, and done exactly 5 cycles after the start edge.
REQ-024 The bench SHALL cover x_in=127. Required response: d_o4=0, d_o3=-13, d_o2=-12, d_o1=214, f_out=118.
REQ-025 The bench SHALL cover x_in=-128 to check truncation toward zero. Required response: d_o4=-1, d_o3=-12, d_o2=13, d_o1=211, f_out=-118.
REQ-026 The bench SHALL cover x_in=64 started, then x_in=-128 and start=1 applied during RUN. Required response: f_out=61 with no second evaluation, and busy stays high exactly 5 cycles.
REQ-027 The bench SHALL cover back-to-back operation: start held high continuously with x_in=127 then 0. Required response: done pulses 6 cycles apart carrying f_out=118 then 0.
REQ-028 The bench SHALL cover reset=0 asserted in the 3rd RUN cycle. Required response: next cycle busy=0, done=0, f_out=0 and d_o1..d_o4=0, with no done pulse. A following start with x_in=0 SHALL complete normally with f_out=0.
